// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared status-bit layout, response tag type and status consistency check
package fp_mul_pkg;
  localparam int STATUS_W = 8;
  localparam int ZERO     = 0;
  localparam int INF      = 1;
  localparam int NAN      = 2;
  localparam int TINY     = 3;
  localparam int HUGE     = 4;
  localparam int INEXACT  = 5;
  // Wide enough for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
  function automatic logic status_illegal(input logic [STATUS_W-1:0] s);
    return (|s[7:6]) |
           (s[ZERO] & s[INF])  | (s[ZERO] & s[NAN])  | (s[ZERO] & s[HUGE]) |
           (s[INF]  & s[TINY]) | (s[NAN]  & s[TINY]) | (s[NAN]  & s[HUGE]) |
           (s[NAN]  & s[INEXACT]) | (s[TINY] & s[HUGE]);
  endfunction
endpackage

// File: rtl/fp_mul_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant starting at an internal pointer
// Ports: i_clk, i_rst_n (async low); i_req request vector; i_advance moves the
// pointer past the current winner; o_grant one-hot or zero grant.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic [PW-1:0] w_idx;
  logic          w_found;
  always_comb begin
    o_grant = '0;
    w_next  = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_next         = PW'((int'(r_ptr) + k + 1) % NREQ);
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= '0;
    else if (i_advance) r_ptr <= w_next;
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one pipelined FP multiplier among NREQ requesters
// Ports: i_clk, i_rst_n (async low), i_en gates new grants;
// i_req_valid/o_req_ready/i_req_a/i_req_b requester side (slice i = requester i);
// o_mul_issue/o_mul_a/o_mul_b/i_mul_z/i_mul_status multiplier side;
// o_rsp_valid/o_rsp_z/o_rsp_status routed responses; o_sticky/i_sticky_clr
// per-requester exception flags; o_status_err sticky illegal-status flag; o_busy.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int LAT  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [NREQ-1:0]     i_req_valid,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic [NREQ*W-1:0]   i_req_a,
  input  logic [NREQ*W-1:0]   i_req_b,
  output logic                o_mul_issue,
  output logic [W-1:0]        o_mul_a,
  output logic [W-1:0]        o_mul_b,
  input  logic [W-1:0]        i_mul_z,
  input  logic [STATUS_W-1:0] i_mul_status,
  output logic [NREQ-1:0]     o_rsp_valid,
  output logic [W-1:0]        o_rsp_z,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic [NREQ*6-1:0]   o_sticky,
  input  logic [NREQ-1:0]     i_sticky_clr,
  output logic                o_status_err,
  output logic                o_busy
);
  logic [NREQ-1:0]     w_grant;
  logic [TAG_ID_W-1:0] w_gid;
  logic [W-1:0]        w_a;
  logic [W-1:0]        w_b;
  logic                w_busy;
  tag_t                w_cap;
  logic                r_issue;
  logic [TAG_ID_W-1:0] r_issue_id;
  logic [W-1:0]        r_mul_a;
  logic [W-1:0]        r_mul_b;
  tag_t                r_tag [LAT];
  logic [NREQ-1:0]     r_rsp_valid;
  logic [W-1:0]        r_rsp_z;
  logic [STATUS_W-1:0] r_rsp_status;
  logic [NREQ*6-1:0]   r_sticky;
  logic                r_err;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid & {NREQ{i_en}}),
    .i_advance (|w_grant),
    .o_grant   (w_grant)
  );
  always_comb begin
    w_gid = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) begin
        w_gid = TAG_ID_W'(i);
        w_a   = i_req_a[i*W +: W];
        w_b   = i_req_b[i*W +: W];
      end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_issue    <= 1'b0;
      r_issue_id <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
    end else begin
      r_issue <= |w_grant;
      if (|w_grant) begin
        r_issue_id <= w_gid;
        r_mul_a    <= w_a;
        r_mul_b    <= w_b;
      end
    end
  // The issue register acts as stage 0, so the last tag stage lines up with
  // the cycle the multiplier presents the matching result.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= tag_t'{valid: r_issue, id: r_issue_id};
      for (int k = 1; k < LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  assign w_cap = r_tag[LAT-1];
  // A clear on a slice being updated in the same cycle keeps only the new bits.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rsp_valid  <= '0;
      r_rsp_z      <= '0;
      r_rsp_status <= '0;
      r_sticky     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_rsp_valid <= w_cap.valid ? NREQ'(1) << w_cap.id : '0;
      if (w_cap.valid) begin
        r_rsp_z      <= i_mul_z;
        r_rsp_status <= i_mul_status;
      end
      r_err <= r_err | (w_cap.valid & status_illegal(i_mul_status));
      for (int i = 0; i < NREQ; i++)
        r_sticky[i*6 +: 6] <= ((w_cap.valid && w_cap.id == TAG_ID_W'(i)) ? i_mul_status[5:0] : 6'b0) |
                              (i_sticky_clr[i] ? 6'b0 : r_sticky[i*6 +: 6]);
    end
  always_comb begin
    w_busy = r_issue | (|r_rsp_valid);
    for (int k = 0; k < LAT; k++) w_busy = w_busy | r_tag[k].valid;
  end
  assign o_req_ready  = w_grant;
  assign o_mul_issue  = r_issue;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_z      = r_rsp_z;
  assign o_rsp_status = r_rsp_status;
  assign o_sticky     = r_sticky;
  assign o_status_err = r_err;
  assign o_busy       = w_busy;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed checks of fp_mul_arbiter against a mock 2-cycle multiplier
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] sticky_clr = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic mul_issue;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_z;
  logic [W-1:0] rsp_z;
  logic [7:0] mul_status;
  logic [7:0] rsp_status;
  logic [N*6-1:0] sticky;
  logic status_err;
  logic busy;
  logic use_ovr = 1'b0;
  logic [W-1:0] ovr_z = '0;
  logic [7:0] ovr_s = '0;
  logic [W-1:0] mz [2];
  logic [7:0] ms [2];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  assign req_a = {a[3], a[2], a[1], a[0]};
  assign req_b = {b[3], b[2], b[1], b[0]};
  // Mock multiplier: result is a+b (or a forced value), status chosen by the bench at issue
  always @(posedge clk) begin
    mz[0] <= use_ovr ? ovr_z : mul_a + mul_b;
    ms[0] <= ovr_s;
    mz[1] <= mz[0];
    ms[1] <= ms[0];
  end
  assign mul_z = mz[1];
  assign mul_status = ms[1];
  fp_mul_arbiter #(.NREQ(N), .W(W), .LAT(LAT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_mul_issue  (mul_issue),
    .o_mul_a      (mul_a),
    .o_mul_b      (mul_b),
    .i_mul_z      (mul_z),
    .i_mul_status (mul_status),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_z      (rsp_z),
    .o_rsp_status (rsp_status),
    .o_sticky     (sticky),
    .i_sticky_clr (sticky_clr),
    .o_status_err (status_err),
    .o_busy       (busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    tick;
    tick;
    chk("rst_issue", mul_issue, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_err", status_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    en = 1'b1;
    // single request from requester 2
    tick;
    a[2] = 32'h40000000;
    b[2] = 32'h40400000;
    use_ovr = 1'b1;
    ovr_z = 32'h40C00000;
    ovr_s = 8'h00;
    req_valid = 4'b0100;
    #1 chk("t1_ready", req_ready, 4'b0100);
    tick;
    req_valid = 4'b0000;
    chk("t1_issue", mul_issue, 1);
    chk("t1_mul_a", mul_a, 32'h40000000);
    chk("t1_mul_b", mul_b, 32'h40400000);
    chk("t1_busy", busy, 1);
    tick;
    chk("t1_issue_off", mul_issue, 0);
    chk("t1_rsp_early1", rsp_valid, 0);
    tick;
    chk("t1_rsp_early2", rsp_valid, 0);
    tick;
    chk("t1_rsp_valid", rsp_valid, 4'b0100);
    chk("t1_rsp_z", rsp_z, 32'h40C00000);
    chk("t1_rsp_status", rsp_status, 8'h00);
    chk("t1_sticky", sticky, 0);
    tick;
    chk("t1_rsp_pulse", rsp_valid, 0);
    chk("t1_rsp_z_hold", rsp_z, 32'h40C00000);
    chk("t1_idle", busy, 0);
    // reset pointer to 0, then all four requesting continuously for 8 cycles
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    use_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin
      a[i] = 32'h01000000 << i;
      b[i] = 32'h11 * (i + 1);
    end
    for (int k = 0; k < 13; k++) begin
      tick;
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk("t2_ready", req_ready, 4'b1 << (k % 4));
      if (k >= 1 && k <= 8) begin
        chk("t2_issue", mul_issue, 1);
        chk("t2_mul_a", mul_a, a[(k-1) % 4]);
      end
      if (k >= 4 && k < 12) begin
        chk("t2_rsp_valid", rsp_valid, 4'b1 << ((k-4) % 4));
        chk("t2_rsp_z", rsp_z, a[(k-4) % 4] + b[(k-4) % 4]);
      end
      if (k == 12) chk("t2_idle", busy, 0);
    end
    // sticky accumulate on requester 1, then clear coinciding with an update
    tick;
    req_valid = 4'b0010;
    ovr_s = 8'h21;
    #1 chk("t3_ready_a", req_ready, 4'b0010);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    tick;
    chk("t3_rsp_valid_a", rsp_valid, 4'b0010);
    chk("t3_rsp_status_a", rsp_status, 8'h21);
    chk("t3_sticky_a", sticky[11:6], 6'b100001);
    chk("t3_err_legal", status_err, 0);
    tick;
    req_valid = 4'b0010;
    ovr_s = 8'h04;
    #1 chk("t3_ready_b", req_ready, 4'b0010);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    sticky_clr = 4'b0010;
    tick;
    sticky_clr = 4'b0000;
    chk("t3_rsp_valid_b", rsp_valid, 4'b0010);
    chk("t3_sticky_setwins", sticky[11:6], 6'b000100);
    tick;
    chk("t3_sticky_hold", sticky, 24'h000100);
    sticky_clr = 4'b0010;
    tick;
    sticky_clr = 4'b0000;
    chk("t3_sticky_clr", sticky, 0);
    // illegal status (zero+nan) on requester 3, then reserved bits
    tick;
    req_valid = 4'b1000;
    ovr_s = 8'h05;
    #1 chk("t4_ready_a", req_ready, 4'b1000);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    chk("t4_err_before", status_err, 0);
    tick;
    chk("t4_rsp_valid_a", rsp_valid, 4'b1000);
    chk("t4_err_set", status_err, 1);
    chk("t4_sticky", sticky[23:18], 6'b000101);
    tick;
    req_valid = 4'b1000;
    ovr_s = 8'hC0;
    #1 chk("t4_ready_b", req_ready, 4'b1000);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    tick;
    chk("t4_rsp_status_b", rsp_status, 8'hC0);
    chk("t4_err_kept", status_err, 1);
    chk("t4_sticky_b", sticky[23:18], 6'b000101);
    ovr_s = 8'h00;
    // drop en with three operations in flight
    for (int k = 0; k < 9; k++) begin
      tick;
      en = (k < 3);
      req_valid = (k < 5) ? 4'b0111 : 4'b0000;
      #1;
      if (k < 3) chk("t5_ready", req_ready, 4'b1 << k);
      else if (k < 5) chk("t5_ready_off", req_ready, 0);
      if (k >= 4 && k <= 6) begin
        chk("t5_rsp_valid", rsp_valid, 4'b1 << (k-4));
        chk("t5_rsp_z", rsp_z, a[k-4] + b[k-4]);
      end
      if (k == 6) chk("t5_busy_last", busy, 1);
      if (k == 7) chk("t5_busy_fall", busy, 0);
    end
    en = 1'b1;
    // asynchronous reset one cycle after issue discards the operation
    tick;
    req_valid = 4'b0001;
    #1 chk("t6_ready", req_ready, 4'b0001);
    tick;
    req_valid = 4'b0000;
    chk("t6_issue", mul_issue, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_issue", mul_issue, 0);
    chk("t6_async_mul_a", mul_a, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_err", status_err, 0);
    chk("t6_async_rsp_z", rsp_z, 0);
    chk("t6_async_sticky", sticky, 0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("t6_no_rsp", rsp_valid, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
